fb_writer: RTL and testbench
============================

Name: fb_writer

Overview:
Upstream write-side sequencer for the dual-half LED framebuffer. It accepts drawing commands (single pixel, filled rectangle, full-screen clear) over a valid/ready handshake. Each command expands into a stream of single-cycle framebuffer writes on the waddr/din/we port. The framebuffer address is {y[5:0], x[5:0]}, so y[5] selects the top or bottom half, matching the panel read side.

Parameters:
WIDTH, 64, display columns (x range 0..WIDTH-1); must be 64 for the 12-bit address map
HEIGHT, 64, display rows (y range 0..HEIGHT-1); must be 64
COLOR_W, 4, bits per pixel written to the framebuffer

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command this cycle
cmd_op  input  2  0=PIXEL, 1=RECT, 2=CLEAR, 3=reserved
cmd_x0  input  6  pixel x, or rectangle corner x
cmd_y0  input  6  pixel y, or rectangle corner y
cmd_x1  input  6  opposite rectangle corner x (RECT only)
cmd_y1  input  6  opposite rectangle corner y (RECT only)
cmd_color  input  COLOR_W  write colour
waddr  output  12  framebuffer write address {y,x}
din  output  COLOR_W  framebuffer write data
we  output  1  framebuffer write strobe, one write per high cycle
busy  output  1  a command is being expanded (the complement of cmd_ready)

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE
  - waddr=0, din=0, we=0, busy=0, cmd_ready=0 while rst is low
  - cmd_ready rises on the first clk edge after rst deasserts
- Acceptance: a command is taken on a clk edge where cmd_valid && cmd_ready. All cmd_* fields are registered at that edge; they may change afterwards.
- States:
  - IDLE: cmd_ready=1, we=0.
    - PIXEL goes to LAST.
    - RECT and CLEAR go to SWEEP.
    - op 3 is accepted and dropped: no write, stay in IDLE.
  - SWEEP: we=1 every cycle, and the address advances row-major (x increments; at xmax, x returns to xmin and y increments). When the address reaches (xmax,ymax), that write is performed and the state goes to LAST_GAP→IDLE, i.e. directly to IDLE with we=0 next cycle.
  - LAST: one cycle with we=1, waddr={y0,x0}, din=cmd_color, then IDLE.
- Rectangle normalisation at accept: xmin=min(x0,x1), xmax=max(x0,x1), and likewise for y. The rectangle is inclusive, so the write count is (xmax-xmin+1)*(ymax-ymin+1). A degenerate rectangle (x0==x1 and y0==y1) writes exactly 1 pixel.
- CLEAR is identical to RECT with corners (0,0) and (63,63): 4096 writes at addresses 0..4095 in order.
- Latency: the first we pulse occurs the cycle after acceptance.
  - PIXEL: busy for 1 cycle; cmd_ready returns on the 2nd cycle after acceptance.
  - RECT with N pixels: we is high for exactly N consecutive cycles, with no bubbles.
- Back-to-back: cmd_ready=0 while busy, so no command is accepted during expansion. The earliest next acceptance is the cycle in which we first deasserts.
- Counters: 6-bit x/y counters plus 12-bit waddr, with no wrap beyond 63 because the terminal compare stops the sweep.
- din holds the command colour for the whole command and is held (not cleared) in IDLE. waddr also holds its last value in IDLE. Only we qualifies a write.
- Reset mid-sweep: we drops immediately (asynchronously) and the remaining writes are abandoned. No partial state survives.

Decomposition:
- Package fb_pkg:
  - typedef enum fb_op_t {OP_PIXEL, OP_RECT, OP_CLEAR, OP_RSVD}
  - writer state enum
  - constants FB_ADDR_W=12, FB_COORD_W=6
  - function fb_addr(x,y) returning {y,x}, shared with the framebuffer/top wiring
- One sub-module is natural: rect_scan, a row-major x/y scanner with start, bounds and a done pulse. fb_writer holds the handshake, normalisation and op decode.

Test Plan:
- Reset: hold rst low for 3 cycles with cmd_valid=1 → we=0, cmd_ready=0, no acceptance. After release, cmd_ready=1 on the next edge.
- PIXEL x=5, y=40, color=0xA → exactly one we pulse, the cycle after accept, with waddr=0xA05 (40*64+5) and din=0xA. cmd_ready is low for 1 cycle.
- RECT corners (10,3) and (8,2), color=3 → 6 consecutive writes to addresses 136,137,138,200,201,202, then we=0. This checks corner swapping.
- CLEAR color=0 → 4096 consecutive we cycles, waddr 0..4095 in order, no gaps. cmd_ready is held low throughout and a cmd_valid presented mid-sweep is not accepted.
- Back-to-back PIXEL, PIXEL with cmd_valid held continuously → the writes appear on alternate cycles, and each command is accepted only when cmd_ready=1.
- Assert rst after 100 writes of a CLEAR → we falls with no clock edge. After release the block is IDLE, and a following PIXEL at (0,0) writes address 0 only.

Source files
------------

// File: rtl/fb_writer_pkg.sv
// Shared types, constants and the framebuffer address map for the LED
// framebuffer write side.
package fb_pkg;

  localparam int FB_ADDR_W  = 12;
  localparam int FB_COORD_W = 6;

  typedef enum logic [1:0] {
    OP_PIXEL = 2'd0,
    OP_RECT  = 2'd1,
    OP_CLEAR = 2'd2,
    OP_RSVD  = 2'd3
  } fb_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_LAST  = 2'd2
  } wr_state_t;

  // Address is {y, x}; y[5] picks the top or bottom panel half.
  function automatic logic [FB_ADDR_W-1:0] fb_addr(
    input logic [FB_COORD_W-1:0] x,
    input logic [FB_COORD_W-1:0] y
  );
    return {y, x};
  endfunction

endpackage

// File: rtl/fb_writer_if.sv
// Command handshake plus framebuffer write port of the writer.
interface fb_writer_if #(
  parameter int COLOR_W = 4
);
  import fb_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [FB_COORD_W-1:0] cmd_x0;
  logic [FB_COORD_W-1:0] cmd_y0;
  logic [FB_COORD_W-1:0] cmd_x1;
  logic [FB_COORD_W-1:0] cmd_y1;
  logic [COLOR_W-1:0]    cmd_color;
  logic [FB_ADDR_W-1:0]  waddr;
  logic [COLOR_W-1:0]    din;
  logic                  we;
  logic                  busy;

  // Command source / framebuffer side.
  modport master (
    output cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
    input  cmd_ready, waddr, din, we, busy
  );

  // The writer itself.
  modport slave (
    input  cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
    output cmd_ready, waddr, din, we, busy
  );

endinterface

// File: rtl/fb_writer_rect_scan.sv
// Row-major x/y scanner: loads bounds on start, steps x then y, and flags
// the terminal (xmax,ymax) position so the owner can stop stepping.
module rect_scan
  import fb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  step,
  input  logic [FB_COORD_W-1:0] xmin,
  input  logic [FB_COORD_W-1:0] xmax,
  input  logic [FB_COORD_W-1:0] ymin,
  input  logic [FB_COORD_W-1:0] ymax,
  output logic [FB_COORD_W-1:0] x,
  output logic [FB_COORD_W-1:0] y,
  output logic                  done
);

  logic [FB_COORD_W-1:0] xmin_q, xmax_q, ymax_q;

  assign done = (x == xmax_q) && (y == ymax_q);

  // Bound capture at start, then row-major advance until the terminal cell.
  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // the async active-low reset clears position and bounds together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x      <= '0;
      y      <= '0;
      xmin_q <= '0;
      xmax_q <= '0;
      ymax_q <= '0;
    end else if (start) begin
      x      <= xmin;
      y      <= ymin;
      xmin_q <= xmin;
      xmax_q <= xmax;
      ymax_q <= ymax;
    end else if (step && !done) begin
      if (x == xmax_q) begin
        x <= xmin_q;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fb_writer.sv
// Drawing-command front end: accepts PIXEL/RECT/CLEAR over valid/ready,
// normalises rectangle corners and expands each command into one
// framebuffer write per cycle.
module fb_writer
  import fb_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int HEIGHT  = 64,
  parameter int COLOR_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  fb_writer_if.slave  bus
);

  wr_state_t state_q, state_d;
  logic      ready_en_q;
  logic [COLOR_W-1:0] din_q;

  logic accept, scan_start, scan_step, scan_done;
  logic ready_c, busy_c, we_c;
  logic [FB_COORD_W-1:0] lo_x, hi_x, lo_y, hi_y, scan_x, scan_y;
  fb_op_t op;

  assign op = fb_op_t'(bus.cmd_op);

  // Corner normalisation; CLEAR is the full-screen rectangle.
  // NOTE: every always_comb output gets a default first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    lo_x = bus.cmd_x0;
    hi_x = bus.cmd_x0;
    lo_y = bus.cmd_y0;
    hi_y = bus.cmd_y0;
    case (op)
      OP_RECT: begin
        lo_x = (bus.cmd_x0 < bus.cmd_x1) ? bus.cmd_x0 : bus.cmd_x1;
        hi_x = (bus.cmd_x0 < bus.cmd_x1) ? bus.cmd_x1 : bus.cmd_x0;
        lo_y = (bus.cmd_y0 < bus.cmd_y1) ? bus.cmd_y0 : bus.cmd_y1;
        hi_y = (bus.cmd_y0 < bus.cmd_y1) ? bus.cmd_y1 : bus.cmd_y0;
      end
      OP_CLEAR: begin
        lo_x = '0;
        hi_x = FB_COORD_W'(WIDTH - 1);
        lo_y = '0;
        hi_y = FB_COORD_W'(HEIGHT - 1);
      end
      default: ;
    endcase
  end

  // State register plus the one-edge-late ready enable after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
    end
  end

  // Next-state: decode the accepted op, leave SWEEP on the terminal cell.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (op)
            OP_PIXEL:         state_d = ST_LAST;
            OP_RECT, OP_CLEAR: state_d = ST_SWEEP;
            default:          state_d = ST_IDLE;
          endcase
        end
      end
      ST_SWEEP: if (scan_done) state_d = ST_IDLE;
      ST_LAST:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs: ready only in IDLE once out of reset; every busy cycle writes.
  always_comb begin
    ready_c    = ready_en_q && (state_q == ST_IDLE);
    busy_c     = (state_q != ST_IDLE);
    we_c       = (state_q != ST_IDLE);
    accept     = bus.cmd_valid && ready_c;
    scan_start = accept && (op != OP_RSVD);
    scan_step  = (state_q == ST_SWEEP);
  end

  // Colour latched per command and held through IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            din_q <= '0;
    else if (scan_start) din_q <= bus.cmd_color;
  end

  rect_scan u_scan (
    .clk   (clk),
    .rst   (rst),
    .start (scan_start),
    .step  (scan_step),
    .xmin  (lo_x),
    .xmax  (hi_x),
    .ymin  (lo_y),
    .ymax  (hi_y),
    .x     (scan_x),
    .y     (scan_y),
    .done  (scan_done)
  );

  assign bus.cmd_ready = ready_c;
  assign bus.busy      = busy_c;
  assign bus.we        = we_c;
  assign bus.din       = din_q;
  assign bus.waddr     = fb_addr(scan_x, scan_y);

endmodule

// File: tb/tb_fb_writer.sv
// Directed bench for fb_writer: reset, pixel, swapped-corner rectangle,
// degenerate rectangle, clear, reserved op, back-to-back and mid-sweep reset.
module tb_fb_writer;
  import fb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  fb_writer_if #(.COLOR_W(4)) bus ();

  fb_writer #(.WIDTH(64), .HEIGHT(64), .COLOR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one command at a negedge; returns at the negedge of the first
  // output cycle after acceptance.
  task automatic send(input logic [1:0] op, input logic [5:0] x0, input logic [5:0] y0,
                      input logic [5:0] x1, input logic [5:0] y1, input logic [3:0] color);
    check("send_ready", {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_op    = op;
    bus.cmd_x0    = x0;
    bus.cmd_y0    = y0;
    bus.cmd_x1    = x1;
    bus.cmd_y1    = y1;
    bus.cmd_color = color;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  int rect_addr [6] = '{136, 137, 138, 200, 201, 202};

  initial begin
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd0;
    bus.cmd_x0    = 6'd1;
    bus.cmd_y0    = 6'd1;
    bus.cmd_x1    = 6'd0;
    bus.cmd_y1    = 6'd0;
    bus.cmd_color = 4'hF;

    // Reset held for 3 cycles with a command offered.
    repeat (3) begin
      @(negedge clk);
      check("rst_we",    {31'd0, bus.we},        32'd0);
      check("rst_ready", {31'd0, bus.cmd_ready}, 32'd0);
      check("rst_busy",  {31'd0, bus.busy},      32'd0);
    end
    check("rst_waddr", {20'd0, bus.waddr}, 32'd0);
    check("rst_din",   {28'd0, bus.din},   32'd0);
    bus.cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rel_ready_pre", {31'd0, bus.cmd_ready}, 32'd0);
    @(negedge clk);
    check("rel_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("rel_we",    {31'd0, bus.we},        32'd0);

    // PIXEL (5,40) colour A.
    send(2'd0, 6'd5, 6'd40, 6'd0, 6'd0, 4'hA);
    check("pix_we",    {31'd0, bus.we},        32'd1);
    check("pix_waddr", {20'd0, bus.waddr},     32'hA05);
    check("pix_din",   {28'd0, bus.din},       32'hA);
    check("pix_ready", {31'd0, bus.cmd_ready}, 32'd0);
    check("pix_busy",  {31'd0, bus.busy},      32'd1);
    @(negedge clk);
    check("pix_we_end", {31'd0, bus.we},        32'd0);
    check("pix_rdy_end", {31'd0, bus.cmd_ready}, 32'd1);
    check("pix_hold_a", {20'd0, bus.waddr},     32'hA05);
    check("pix_hold_d", {28'd0, bus.din},       32'hA);

    // RECT (10,3)-(8,2): corners swapped.
    send(2'd1, 6'd10, 6'd3, 6'd8, 6'd2, 4'h3);
    for (int i = 0; i < 6; i++) begin
      check("rect_we",    {31'd0, bus.we},    32'd1);
      check("rect_waddr", {20'd0, bus.waddr}, rect_addr[i]);
      check("rect_din",   {28'd0, bus.din},   32'h3);
      @(negedge clk);
    end
    check("rect_we_end",  {31'd0, bus.we},        32'd0);
    check("rect_rdy_end", {31'd0, bus.cmd_ready}, 32'd1);

    // Degenerate rectangle: exactly one write.
    send(2'd1, 6'd20, 6'd20, 6'd20, 6'd20, 4'h7);
    check("deg_we",    {31'd0, bus.we},    32'd1);
    check("deg_waddr", {20'd0, bus.waddr}, 32'd1300);
    @(negedge clk);
    check("deg_we_end", {31'd0, bus.we}, 32'd0);

    // CLEAR colour 0 with a command offered mid-sweep.
    send(2'd2, 6'd0, 6'd0, 6'd0, 6'd0, 4'h0);
    for (int i = 0; i < 4096; i++) begin
      check("clr_we",    {31'd0, bus.we},        32'd1);
      check("clr_waddr", {20'd0, bus.waddr},     i);
      check("clr_ready", {31'd0, bus.cmd_ready}, 32'd0);
      if (i == 0) check("clr_din", {28'd0, bus.din}, 32'h0);
      if (i == 2000) begin
        bus.cmd_op = 2'd0; bus.cmd_x0 = 6'd1; bus.cmd_y0 = 6'd1;
        bus.cmd_color = 4'h5; bus.cmd_valid = 1'b1;
      end
      if (i == 2010) bus.cmd_valid = 1'b0;
      if (i < 4095) @(negedge clk);
    end
    @(negedge clk);
    check("clr_we_end",  {31'd0, bus.we},        32'd0);
    check("clr_rdy_end", {31'd0, bus.cmd_ready}, 32'd1);
    check("clr_hold_a",  {20'd0, bus.waddr},     32'd4095);
    check("clr_hold_d",  {28'd0, bus.din},       32'h0);
    @(negedge clk);
    check("clr_no_late", {31'd0, bus.we},        32'd0);

    // Back-to-back PIXELs with cmd_valid held high.
    check("b2b_ready0", {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_op = 2'd0; bus.cmd_x0 = 6'd3; bus.cmd_y0 = 6'd7;
    bus.cmd_color = 4'h5; bus.cmd_valid = 1'b1;
    @(negedge clk);
    check("b2b_we1",    {31'd0, bus.we},        32'd1);
    check("b2b_addr1",  {20'd0, bus.waddr},     32'd451);
    check("b2b_din1",   {28'd0, bus.din},       32'h5);
    check("b2b_rdy1",   {31'd0, bus.cmd_ready}, 32'd0);
    bus.cmd_x0 = 6'd60; bus.cmd_y0 = 6'd1; bus.cmd_color = 4'h9;
    @(negedge clk);
    check("b2b_gap_we",  {31'd0, bus.we},        32'd0);
    check("b2b_gap_rdy", {31'd0, bus.cmd_ready}, 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("b2b_we2",    {31'd0, bus.we},    32'd1);
    check("b2b_addr2",  {20'd0, bus.waddr}, 32'd124);
    check("b2b_din2",   {28'd0, bus.din},   32'h9);
    @(negedge clk);
    check("b2b_we_end", {31'd0, bus.we},        32'd0);
    check("b2b_rdy_end", {31'd0, bus.cmd_ready}, 32'd1);

    // Reserved op: accepted, no write, nothing changes.
    send(2'd3, 6'd9, 6'd9, 6'd9, 6'd9, 4'h1);
    check("rsv_we",    {31'd0, bus.we},        32'd0);
    check("rsv_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("rsv_waddr", {20'd0, bus.waddr},     32'd124);
    check("rsv_din",   {28'd0, bus.din},       32'h9);

    // Reset after 100 writes of a CLEAR.
    send(2'd2, 6'd0, 6'd0, 6'd0, 6'd0, 4'hF);
    for (int i = 0; i < 100; i++) begin
      check("mid_we",    {31'd0, bus.we},    32'd1);
      check("mid_waddr", {20'd0, bus.waddr}, i);
      if (i < 99) @(negedge clk);
    end
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_we",    {31'd0, bus.we},        32'd0);
    check("mid_rst_busy",  {31'd0, bus.busy},      32'd0);
    check("mid_rst_ready", {31'd0, bus.cmd_ready}, 32'd0);
    check("mid_rst_waddr", {20'd0, bus.waddr},     32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("post_we",    {31'd0, bus.we},        32'd0);
    send(2'd0, 6'd0, 6'd0, 6'd0, 6'd0, 4'h6);
    check("post_pix_we",   {31'd0, bus.we},    32'd1);
    check("post_pix_addr", {20'd0, bus.waddr}, 32'd0);
    check("post_pix_din",  {28'd0, bus.din},   32'h6);
    repeat (3) begin
      @(negedge clk);
      check("post_idle_we", {31'd0, bus.we}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
